// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin arbiter for the shared VGA plot port.
// Three pixel producers (draw, RAM restore, cursor) compete for the port via
// request/grant. Owners may lock the port for a burst; unlocked owners are
// preempted after MAX_HOLD transfers if someone else is waiting.
module vga_plot_arbiter #(
    parameter  int SCREEN_WIDTH  = 160,
    parameter  int SCREEN_HEIGHT = 120,
    parameter  int MAX_HOLD      = 25,
    localparam int XW            = $clog2(SCREEN_WIDTH) + 1,
    localparam int YW            = $clog2(SCREEN_HEIGHT) + 1,
    localparam int CW            = $clog2(MAX_HOLD + 1)
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic [2:0]    iReq,
    input  logic [2:0]    iLock,
    input  logic [XW-1:0] iX0,
    input  logic [XW-1:0] iX1,
    input  logic [XW-1:0] iX2,
    input  logic [YW-1:0] iY0,
    input  logic [YW-1:0] iY1,
    input  logic [YW-1:0] iY2,
    input  logic [2:0]    iColour0,
    input  logic [2:0]    iColour1,
    input  logic [2:0]    iColour2,
    output logic [2:0]    oGrant,
    output logic [1:0]    oOwner,
    output logic [XW-1:0] oX_pixel,
    output logic [YW-1:0] oY_pixel,
    output logic [2:0]    oColour,
    output logic          oPlot
);

    localparam logic [1:0]    OWN_IDLE  = 2'd3;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);

    // First requesting index scanning upward from last+1 with wrap; 3 if none.
    function automatic logic [1:0] f_rr(input logic [2:0] mask, input logic [1:0] last);
        logic [1:0] pick;
        int         t;
        pick = OWN_IDLE;
        for (int k = 3; k >= 1; k--) begin
            t = int'(last) + k;
            if (t >= 3) t = t - 3;
            if (mask[t[1:0]]) pick = t[1:0];
        end
        return pick;
    endfunction

    // Saturating hold-counter increment.
    function automatic logic [CW-1:0] f_hold_inc(input logic [CW-1:0] cnt);
        return (cnt >= HOLD_MAX) ? HOLD_MAX : cnt + CW'(1);
    endfunction

    logic [1:0]    r_owner;
    logic [1:0]    r_last;
    logic [CW-1:0] r_hold;
    logic [2:0]    r_grant;
    logic          r_plot;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [2:0]    r_col;

    logic [1:0]    w_owner_nx;
    logic [1:0]    w_last_nx;
    logic [CW-1:0] w_hold_nx;
    logic [2:0]    w_grant_nx;
    logic          w_xfer;
    logic          w_locked;
    logic [2:0]    w_others;
    logic [XW-1:0] w_x_sel;
    logic [YW-1:0] w_y_sel;
    logic [2:0]    w_col_sel;

    assign w_xfer   = |(iReq & r_grant);
    assign w_locked = |(iLock & r_grant);
    assign w_others = iReq & ~r_grant;

    // State register: owner, round-robin pointer, hold counter, grant.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_owner <= OWN_IDLE;
            r_last  <= 2'd2;
            r_hold  <= '0;
            r_grant <= 3'b000;
        end else begin
            r_owner <= w_owner_nx;
            r_last  <= w_last_nx;
            r_hold  <= w_hold_nx;
            r_grant <= w_grant_nx;
        end
    end

    // Next-state: grant/release/lock/preemption decisions.
    always_comb begin
        w_owner_nx = r_owner;
        w_last_nx  = r_last;
        w_hold_nx  = r_hold;
        if (r_owner == OWN_IDLE) begin
            w_owner_nx = f_rr(iReq, r_last);
            w_hold_nx  = '0;
        end else if (w_locked) begin
            w_owner_nx = r_owner;
        end else if (!w_xfer) begin
            w_owner_nx = f_rr(w_others, r_owner);
            w_last_nx  = r_owner;
            w_hold_nx  = '0;
        end else if ((r_hold >= HOLD_LAST) && (|w_others)) begin
            w_owner_nx = f_rr(w_others, r_owner);
            w_last_nx  = r_owner;
            w_hold_nx  = '0;
        end else begin
            w_hold_nx  = f_hold_inc(r_hold);
        end
    end

    // Output decode: one-hot grant from the next owner, pixel source mux.
    always_comb begin
        w_grant_nx = 3'b000;
        w_x_sel    = iX0;
        w_y_sel    = iY0;
        w_col_sel  = iColour0;
        case (w_owner_nx)
            2'd0:    w_grant_nx = 3'b001;
            2'd1:    w_grant_nx = 3'b010;
            2'd2:    w_grant_nx = 3'b100;
            default: w_grant_nx = 3'b000;
        endcase
        case (r_owner)
            2'd1: begin
                w_x_sel   = iX1;
                w_y_sel   = iY1;
                w_col_sel = iColour1;
            end
            2'd2: begin
                w_x_sel   = iX2;
                w_y_sel   = iY2;
                w_col_sel = iColour2;
            end
            default: begin
                w_x_sel   = iX0;
                w_y_sel   = iY0;
                w_col_sel = iColour0;
            end
        endcase
    end

    // Registered VGA pixel outputs: capture on transfer, hold otherwise.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_plot <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
            r_col  <= '0;
        end else begin
            r_plot <= w_xfer;
            if (w_xfer) begin
                r_x   <= w_x_sel;
                r_y   <= w_y_sel;
                r_col <= w_col_sel;
            end
        end
    end

    assign oGrant   = r_grant;
    assign oOwner   = r_owner;
    assign oPlot    = r_plot;
    assign oX_pixel = r_x;
    assign oY_pixel = r_y;
    assign oColour  = r_col;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Testbench for vga_plot_arbiter: vector table plus directed multi-cycle sequences.
module tb_vga_plot_arbiter;

    localparam int XW = 9;
    localparam int YW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req;
    logic [2:0]    lock;
    logic [XW-1:0] x0, x1, x2;
    logic [YW-1:0] y0, y1, y2;
    logic [2:0]    c0, c1, c2;
    logic [2:0]    grant;
    logic [1:0]    owner;
    logic [XW-1:0] xo;
    logic [YW-1:0] yo;
    logic [2:0]    co;
    logic          plot;

    int total = 0;
    int bad   = 0;

    vga_plot_arbiter dut (
        .iClk(clk), .iReset(rst), .iReq(req), .iLock(lock),
        .iX0(x0), .iX1(x1), .iX2(x2),
        .iY0(y0), .iY1(y1), .iY2(y2),
        .iColour0(c0), .iColour1(c1), .iColour2(c2),
        .oGrant(grant), .oOwner(owner),
        .oX_pixel(xo), .oY_pixel(yo), .oColour(co), .oPlot(plot)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          rst;
        logic [2:0]    req;
        logic [2:0]    lock;
        logic [2:0]    g;
        logic [1:0]    own;
        logic          plot;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [2:0]    c;
    } vec_t;

    vec_t tv[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic prev0;
        rst = 1'b0; req = 3'b000; lock = 3'b000;
        x0 = 9'd10;  y0 = 8'd20;  c0 = 3'd1;
        x1 = 9'd37;  y1 = 8'd59;  c1 = 3'd5;
        x2 = 9'd100; y2 = 8'd110; c2 = 3'd6;

        //         rst   req     lock    grant   own   plot  x        y         c
        tv[0]  = '{1'b1, 3'b111, 3'b000, 3'b000, 2'd3, 1'b0, 9'd0,   8'd0,   3'd0};
        tv[1]  = '{1'b1, 3'b111, 3'b000, 3'b000, 2'd3, 1'b0, 9'd0,   8'd0,   3'd0};
        tv[2]  = '{1'b0, 3'b111, 3'b000, 3'b001, 2'd0, 1'b0, 9'd0,   8'd0,   3'd0};
        tv[3]  = '{1'b0, 3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 9'd10,  8'd20,  3'd1};
        tv[4]  = '{1'b0, 3'b110, 3'b000, 3'b010, 2'd1, 1'b0, 9'd10,  8'd20,  3'd1};
        tv[5]  = '{1'b0, 3'b110, 3'b000, 3'b010, 2'd1, 1'b1, 9'd37,  8'd59,  3'd5};
        tv[6]  = '{1'b0, 3'b101, 3'b000, 3'b100, 2'd2, 1'b0, 9'd37,  8'd59,  3'd5};
        tv[7]  = '{1'b0, 3'b101, 3'b000, 3'b100, 2'd2, 1'b1, 9'd100, 8'd110, 3'd6};
        tv[8]  = '{1'b0, 3'b011, 3'b000, 3'b001, 2'd0, 1'b0, 9'd100, 8'd110, 3'd6};
        tv[9]  = '{1'b0, 3'b001, 3'b000, 3'b001, 2'd0, 1'b1, 9'd10,  8'd20,  3'd1};
        tv[10] = '{1'b0, 3'b000, 3'b000, 3'b000, 2'd3, 1'b0, 9'd10,  8'd20,  3'd1};
        tv[11] = '{1'b0, 3'b010, 3'b000, 3'b010, 2'd1, 1'b0, 9'd10,  8'd20,  3'd1};
        tv[12] = '{1'b0, 3'b010, 3'b000, 3'b010, 2'd1, 1'b1, 9'd37,  8'd59,  3'd5};
        tv[13] = '{1'b0, 3'b000, 3'b000, 3'b000, 2'd3, 1'b0, 9'd37,  8'd59,  3'd5};
        tv[14] = '{1'b0, 3'b000, 3'b000, 3'b000, 2'd3, 1'b0, 9'd37,  8'd59,  3'd5};
        tv[15] = '{1'b0, 3'b100, 3'b000, 3'b100, 2'd2, 1'b0, 9'd37,  8'd59,  3'd5};
        tv[16] = '{1'b0, 3'b101, 3'b100, 3'b100, 2'd2, 1'b1, 9'd100, 8'd110, 3'd6};
        tv[17] = '{1'b0, 3'b001, 3'b100, 3'b100, 2'd2, 1'b0, 9'd100, 8'd110, 3'd6};
        tv[18] = '{1'b0, 3'b001, 3'b000, 3'b001, 2'd0, 1'b0, 9'd100, 8'd110, 3'd6};
        tv[19] = '{1'b0, 3'b000, 3'b000, 3'b000, 2'd3, 1'b0, 9'd100, 8'd110, 3'd6};

        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            rst  = tv[i].rst;
            req  = tv[i].req;
            lock = tv[i].lock;
            step();
            chk($sformatf("v%0d grant", i), 32'(grant), 32'(tv[i].g));
            chk($sformatf("v%0d owner", i), 32'(owner), 32'(tv[i].own));
            chk($sformatf("v%0d plot", i),  32'(plot),  32'(tv[i].plot));
            chk($sformatf("v%0d x", i),     32'(xo),    32'(tv[i].x));
            chk($sformatf("v%0d y", i),     32'(yo),    32'(tv[i].y));
            chk($sformatf("v%0d colour", i), 32'(co),   32'(tv[i].c));
        end

        // Lock: requester 0 holds the port with request gaps while 2 waits.
        req = 3'b001; lock = 3'b001;
        step();
        chk("lock grant0", 32'(grant), 32'(3'b001));
        for (int i = 0; i < 60; i++) begin
            req   = {1'b1, 1'b0, (i % 4 == 0)};
            lock  = 3'b001;
            prev0 = req[0];
            step();
            chk($sformatf("lock hold %0d", i), 32'(grant), 32'(3'b001));
            chk($sformatf("lock plot %0d", i), 32'(plot), 32'(prev0));
        end
        req = 3'b100; lock = 3'b000;
        step();
        chk("lock release grant", 32'(grant), 32'(3'b100));
        chk("lock release owner", 32'(owner), 32'd2);

        // Preemption after 25 unlocked transfers while requester 1 waits.
        req = 3'b000;
        step();
        chk("pre idle", 32'(grant), 32'(3'b000));
        req = 3'b011;
        step();
        chk("pre grant0", 32'(grant), 32'(3'b001));
        for (int k = 1; k <= 25; k++) begin
            step();
            chk($sformatf("pre plot %0d", k), 32'(plot), 32'd1);
            chk($sformatf("pre x %0d", k), 32'(xo), 32'd10);
            chk($sformatf("pre grant %0d", k), 32'(grant), (k < 25) ? 32'(3'b001) : 32'(3'b010));
        end
        step();
        chk("pre r1 plot", 32'(plot), 32'd1);
        chk("pre r1 x", 32'(xo), 32'd37);
        chk("pre r1 grant", 32'(grant), 32'(3'b010));

        // Saturation: nobody waiting, then a late request preempts at once.
        req = 3'b010;
        for (int k = 0; k < 30; k++) begin
            step();
            chk($sformatf("sat grant %0d", k), 32'(grant), 32'(3'b010));
        end
        req = 3'b011;
        step();
        chk("sat preempt grant", 32'(grant), 32'(3'b001));
        chk("sat preempt plot", 32'(plot), 32'd1);
        chk("sat preempt x", 32'(xo), 32'd37);

        // Reset during requester 2's 10th locked transfer.
        req = 3'b000;
        step();
        chk("rst idle", 32'(grant), 32'(3'b000));
        req = 3'b100; lock = 3'b100;
        step();
        chk("rst grant2", 32'(grant), 32'(3'b100));
        for (int k = 1; k <= 9; k++) begin
            step();
            chk($sformatf("rst burst grant %0d", k), 32'(grant), 32'(3'b100));
            chk($sformatf("rst burst x %0d", k), 32'(xo), 32'd100);
        end
        rst = 1'b1; req = 3'b101; lock = 3'b100;
        step();
        chk("rst mid grant", 32'(grant), 32'(3'b000));
        chk("rst mid owner", 32'(owner), 32'd3);
        chk("rst mid plot", 32'(plot), 32'd0);
        chk("rst mid x", 32'(xo), 32'd0);
        chk("rst mid hold", 32'(dut.r_hold), 32'd0);
        rst = 1'b0;
        step();
        chk("rst after grant", 32'(grant), 32'(3'b001));
        chk("rst after owner", 32'(owner), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
